// File: rtl/project_blastn_pkg.sv
// Shared definitions for the seed-hit stage: message layouts, base encoding and FSM states.
package project_blastn_pkg;

  localparam int FIELD_W   = 32;
  localparam int BASE_W    = 2;
  localparam int POS_W     = 5;
  localparam int ISTREAM_W = 192;
  localparam int OSTREAM_W = 224;

  // Job message layout, query in the lowest field.
  localparam int I_QUERY_LSB  = 0;
  localparam int I_DB_LSB     = 32;
  localparam int I_QSTART_LSB = 64;
  localparam int I_DSTART_LSB = 96;
  localparam int I_LEN_LSB    = 128;
  localparam int I_SCORE_LSB  = 160;

  // Hit message layout: same fields with hit_pos inserted above the database word.
  localparam int O_QUERY_LSB  = 0;
  localparam int O_DB_LSB     = 32;
  localparam int O_HITPOS_LSB = 64;
  localparam int O_QSTART_LSB = 96;
  localparam int O_DSTART_LSB = 128;
  localparam int O_LEN_LSB    = 160;
  localparam int O_SCORE_LSB  = 192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/project_seed_hit_if.sv
// Job input and hit output streams of the seed-hit stage.
// A transfer happens on the rising clk edge where val and rdy are both high; the
// sender holds val and msg stable until then, and rdy never depends on val.
interface project_seed_hit_if;
  import project_blastn_pkg::*;

  logic                 istream_val;
  logic                 istream_rdy;
  logic [ISTREAM_W-1:0] istream_msg;
  logic                 ostream_val;
  logic                 ostream_rdy;
  logic [OSTREAM_W-1:0] ostream_msg;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

endinterface

// File: rtl/project_seed_cmp.sv
// Diagonal-0 k-mer compare: do seed_len bases starting at pos agree in query and database?
module project_seed_cmp
  import project_blastn_pkg::*;
#(
  parameter int query_len = 16,
  parameter int seed_len  = 4
) (
  input  logic [FIELD_W-1:0] query,
  input  logic [FIELD_W-1:0] database,
  input  logic [POS_W-1:0]   pos,
  output logic               match
);

  // Bases beyond the word length never take part in a comparison.
  localparam logic [FIELD_W-1:0] WORD_MASK =
    (query_len >= FIELD_W / BASE_W) ? '1 : FIELD_W'((64'd1 << (BASE_W * query_len)) - 64'd1);

  logic [FIELD_W-1:0] diff;

  always_comb begin
    diff  = ((query ^ database) & WORD_MASK) >> {pos, 1'b0};
    match = ~|diff[BASE_W*seed_len-1:0];
  end

endmodule

// File: rtl/project_seed_hit.sv
// Seed-hit finder: scans one k-mer position per cycle along diagonal 0 and emits a
// message per non-overlapping exact seed match, carrying the job fields through.
module project_seed_hit
  import project_blastn_pkg::*;
#(
  parameter int query_len    = 16,
  parameter int database_len = 16,
  parameter int seed_len     = 4
) (
  input  logic               clk,
  input  logic               reset,
  project_seed_hit_if.slave  io,
  output logic               busy,
  output state_e             state_dbg
);

  localparam int WORD_LEN = (query_len < database_len) ? query_len : database_len;
  localparam int LAST_POS = WORD_LEN - seed_len;

  state_e             state;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   hit_pos;
  logic               ostream_val_q;
  logic [FIELD_W-1:0] query_r;
  logic [FIELD_W-1:0] db_r;
  logic [FIELD_W-1:0] qstart_r;
  logic [FIELD_W-1:0] dstart_r;
  logic [FIELD_W-1:0] len_r;
  logic [FIELD_W-1:0] score_r;
  logic               match;
  logic [POS_W:0]     resume_pos;

  project_seed_cmp #(
    .query_len (WORD_LEN),
    .seed_len  (seed_len)
  ) u_cmp (
    .query    (query_r),
    .database (db_r),
    .pos      (pos),
    .match    (match)
  );

  // Scanning restarts just past the emitted seed so overlapping hits are skipped.
  assign resume_pos = {1'b0, hit_pos} + (POS_W+1)'(seed_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pos           <= '0;
      hit_pos       <= '0;
      ostream_val_q <= 1'b0;
      query_r       <= '0;
      db_r          <= '0;
      qstart_r      <= '0;
      dstart_r      <= '0;
      len_r         <= '0;
      score_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.istream_val) begin
            query_r  <= io.istream_msg[I_QUERY_LSB  +: FIELD_W];
            db_r     <= io.istream_msg[I_DB_LSB     +: FIELD_W];
            qstart_r <= io.istream_msg[I_QSTART_LSB +: FIELD_W];
            dstart_r <= io.istream_msg[I_DSTART_LSB +: FIELD_W];
            len_r    <= io.istream_msg[I_LEN_LSB    +: FIELD_W];
            score_r  <= io.istream_msg[I_SCORE_LSB  +: FIELD_W];
            pos      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            hit_pos       <= pos;
            ostream_val_q <= 1'b1;
            state         <= EMIT;
          end else if (pos == POS_W'(LAST_POS)) begin
            state <= IDLE;
          end else begin
            pos <= pos + 1'b1;
          end
        end
        EMIT: begin
          if (io.ostream_rdy) begin
            ostream_val_q <= 1'b0;
            if (resume_pos > (POS_W+1)'(LAST_POS)) begin
              state <= IDLE;
            end else begin
              pos   <= resume_pos[POS_W-1:0];
              state <= SCAN;
            end
          end
        end
        default: begin
          ostream_val_q <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign io.istream_rdy = (state == IDLE);
  assign io.ostream_val = ostream_val_q;
  assign io.ostream_msg = {score_r, len_r, dstart_r, qstart_r,
                           {(FIELD_W-POS_W){1'b0}}, hit_pos, db_r, query_r};
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_project_seed_hit.sv
// Directed bench for project_seed_hit: stimulus pushes hand-computed hit messages into
// exp_q and an independent monitor pops and compares them on every output transfer.
module tb_project_seed_hit;
  import project_blastn_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   busy;
  state_e state_dbg;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     lat;
  int     wait_n;

  logic [OSTREAM_W-1:0] exp_q[$];
  logic                 stalled = 1'b0;
  logic [OSTREAM_W-1:0] stall_msg;

  project_seed_hit_if sif();

  project_seed_hit #(
    .query_len    (16),
    .database_len (16),
    .seed_len     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (sif),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [OSTREAM_W-1:0] act,
                       input logic [OSTREAM_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [31:0] q, d, qs, ds, ln, sc, input int hp);
    exp_q.push_back({sc, ln, ds, qs, 32'(hp), d, q});
  endfunction

  // Called and returns at #1 after a rising edge; the accept edge is the last edge consumed.
  task automatic send_job(input logic [31:0] q, d, qs, ds, ln, sc);
    int n = 0;
    while (!sif.istream_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got istream_rdy=0 expected 1");
    end
    sif.istream_val = 1'b1;
    sif.istream_msg = {sc, ln, ds, qs, d, q};
    @(posedge clk); #1;
    sif.istream_val = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || !sif.istream_rdy) && n < 300);
    check({name, "_idle_rdy"}, sif.istream_rdy, 1);
    check({name, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_val", sif.ostream_val, 1);
          check("stall_msg", sif.ostream_msg, stall_msg);
        end
        if (sif.ostream_val && sif.ostream_rdy) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_msg: got %0h expected no message", sif.ostream_msg);
          end else begin
            check("hit_msg", sif.ostream_msg, exp_q.pop_front());
          end
        end else if (sif.ostream_val) begin
          stalled   = 1'b1;
          stall_msg = sif.ostream_msg;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b0;
    sif.istream_val = 1'b0;
    sif.istream_msg = '0;
    sif.ostream_rdy = 1'b1;

    @(negedge clk);
    check("rst_oval", sif.ostream_val, 0);
    check("rst_omsg", sif.ostream_msg, 0);
    check("rst_busy", busy, 0);
    check("rst_irdy", sif.istream_rdy, 1);
    check("rst_state", state_dbg, IDLE);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Identical words: a hit at every position, non-overlapping ones at 0,4,8,12.
    for (int p = 0; p < 16; p += 4)
      push_exp(32'h01234567, 32'h01234567, 32'h11111111, 32'h22222222,
               32'h33333333, 32'h44444444, p);
    send_job(32'h01234567, 32'h01234567, 32'h11111111, 32'h22222222,
             32'h33333333, 32'h44444444);
    wait_idle("t027");

    // Every base differs: thirteen scan cycles, no output.
    send_job(32'hFFFFFFFF, 32'h00000000, 32'hA0A0A0A0, 32'hB0B0B0B0,
             32'hC0C0C0C0, 32'hD0D0D0D0);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      check("t028_oval", sif.ostream_val, 0);
      check("t028_busy", busy, (k <= 12));
    end
    @(posedge clk); #1;

    // Only the top four bases agree: single hit at 12, valid 13 edges after accept.
    push_exp(32'hFF000000, 32'hFF555555, 32'h01010101, 32'h02020202,
             32'h03030303, 32'h04040404, 12);
    send_job(32'hFF000000, 32'hFF555555, 32'h01010101, 32'h02020202,
             32'h03030303, 32'h04040404);
    lat = 0;
    @(negedge clk);
    while (!sif.ostream_val && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t029_latency", lat, 13);
    wait_idle("t029");

    // Back-pressure on the first hit, with job pulses that must be ignored.
    sif.ostream_rdy = 1'b0;
    for (int p = 0; p < 16; p += 4)
      push_exp(32'h01234567, 32'h01234567, 32'h11111111, 32'h22222222,
               32'h33333333, 32'h44444444, p);
    send_job(32'h01234567, 32'h01234567, 32'h11111111, 32'h22222222,
             32'h33333333, 32'h44444444);
    wait_n = 0;
    while (!sif.ostream_val && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("t030_first_val", sif.ostream_val, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sif.istream_val = 1'b1;
      sif.istream_msg = {6{32'hDEAD0000 | 32'(i)}};
      check("t030_irdy_low", sif.istream_rdy, 0);
    end
    sif.istream_val = 1'b0;
    sif.ostream_rdy = 1'b1;
    wait_idle("t030");

    // Reset in the middle of a scan discards the job.
    for (int p = 0; p < 16; p += 4)
      push_exp(32'h01234567, 32'h01234567, 32'h11111111, 32'h22222222,
               32'h33333333, 32'h44444444, p);
    send_job(32'h01234567, 32'h01234567, 32'h11111111, 32'h22222222,
             32'h33333333, 32'h44444444);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t031_pre_busy", busy, 1);
    check("t031_pre_state", state_dbg, SCAN);
    #2 reset = 1'b0;
    #1;
    check("t031_oval", sif.ostream_val, 0);
    check("t031_omsg", sif.ostream_msg, 0);
    check("t031_busy", busy, 0);
    check("t031_irdy", sif.istream_rdy, 1);
    check("t031_left", exp_q.size(), 3);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    push_exp(32'hFF000000, 32'hFF555555, 32'h0A0A0A0A, 32'h0B0B0B0B,
             32'h0C0C0C0C, 32'h0D0D0D0D, 12);
    send_job(32'hFF000000, 32'hFF555555, 32'h0A0A0A0A, 32'h0B0B0B0B,
             32'h0C0C0C0C, 32'h0D0D0D0D);
    wait_idle("t031_after");

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/project_seed_hit.md
PROJECT_SEED_HIT -- requirements
Module: project_seed_hit

Interface
REQ-001 SHALL have parameter query_len, default 16, number of 2-bit bases in the query word (≤16).
REQ-002 SHALL have parameter database_len, default 16, number of bases in the database word; must equal query_len.
REQ-003 SHALL have parameter seed_len, default 4, exact-match k-mer length (1..query_len).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 istream_val  input  1  upstream job valid.
REQ-007 istream_rdy  output  1  block can accept a job.
REQ-008 istream_msg  input  192  {addr_score, addr_len, addr_d_start, addr_q_start, database, query}, 32 bits each, query at [31:0].
REQ-009 ostream_val  output  1  hit message valid.
REQ-010 ostream_rdy  input  1  downstream UGPE ready.
REQ-011 ostream_msg  output  224  {addr_score, addr_len, addr_d_start, addr_q_start, hit_pos, database, query}, query at [31:0].
REQ-012 busy  output  1  high whenever state ≠ IDLE.

Function
REQ-013 Base i of a word SHALL be bits [2i+1:2i]; a hit at position p SHALL mean query bases p..p+seed_len-1 equal database bases p..p+seed_len-1 (diagonal 0).
REQ-014 FSM SHALL have states IDLE, SCAN, EMIT; istream_rdy = (state==IDLE).
REQ-015 On istream_val&&istream_rdy the block SHALL latch all six fields, set pos=0, enter SCAN.
REQ-016 In SCAN, each cycle SHALL test exactly one position pos; on match set hit_pos=pos and enter EMIT; else if pos==query_len-seed_len return to IDLE, otherwise pos++.
REQ-017 In EMIT, ostream_val SHALL be 1 and ostream_msg SHALL hold latched fields with hit_pos zero-extended to 32 bits, stable until ostream_rdy.
REQ-018 On EMIT handshake, if hit_pos+seed_len > query_len-seed_len go IDLE, else pos=hit_pos+seed_len and enter SCAN (overlapping hits suppressed).
REQ-019 Latency: first hit at p SHALL raise ostream_val p+1 cycles after the accept edge.
REQ-020 A job with no hit SHALL produce no output and return to IDLE after query_len-seed_len+1 SCAN cycles.
REQ-021 istream_val while busy SHALL be ignored (not latched); ostream_val SHALL be 0 outside EMIT.
REQ-022 addr_* fields, query and database SHALL pass through bit-exact to every hit message of that job.

Reset
REQ-023 reset low SHALL immediately force IDLE, pos=0, hit_pos=0, ostream_val=0, ostream_msg=0, busy=0, istream_rdy=1 after release.
REQ-024 reset asserted mid-SCAN or mid-EMIT SHALL discard the job with no partial output.

Structure
REQ-025 Shared package project_blastn_pkg SHALL hold message widths, field bit offsets, base encoding width (2), and the state enum.
REQ-026 Combinational k-mer comparator SHALL be sub-module project_seed_cmp (inputs query, database, pos; output match).

Verification
REQ-027 query=database=0x01234567, addrs 0x11111111/0x22222222/0x33333333/0x44444444, ostream_rdy=1 -> four messages hit_pos 0,4,8,12, addrs unchanged, then istream_rdy=1.
REQ-028 query=0xFFFFFFFF, database=0x00000000 -> no ostream_val, IDLE after 13 SCAN cycles.
REQ-029 query=0xFF000000, database=0xFF555555 -> exactly one message, hit_pos=12, ostream_val rises 13 cycles after accept.
REQ-030 Test 027 with ostream_rdy low 5 cycles in first EMIT -> ostream_msg stable, no lost/duplicated hits, istream_val pulses ignored.
REQ-031 reset low during SCAN of test 027 -> outputs zero immediately; next job after release processes normally.
